handshaking_resp_xbar_2x2: RTL and testbench



---
 rtl/hs_xbar_pkg.sv | 15 +
 rtl/hs_resp_arb_slice.sv | 65 ++++++
 rtl/handshaking_resp_xbar_2x2.sv | 67 ++++++
 tb/tb_handshaking_resp_xbar_2x2.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hs_xbar_pkg.sv
// Shared constants and helpers for the valid/ready response crossbar.
// Port IDs encode both the destination tag on slaves and the source tag on masters.
package hs_xbar_pkg;

    localparam int DEF_DATA_W = 8;

    localparam logic PORT_1 = 1'b0;
    localparam logic PORT_2 = 1'b1;

    // Port ID of the lowest-numbered requester in a two-bit request vector.
    function automatic logic first_req(input logic [1:0] req);
        return req[0] ? PORT_1 : PORT_2;
    endfunction

endpackage

// File: rtl/hs_resp_arb_slice.sv
// Per-master slice: arbitrates between S1/S2 requests and holds a one-entry output register.
// RESP_XBAR_RR_EN selects round-robin arbitration; otherwise S1 has fixed priority.
module hs_resp_arb_slice
    import hs_xbar_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] data_s1,
    input  logic [DATA_W-1:0] data_s2,
    input  logic              ready_out,
    output logic [1:0]        grant,
    output logic [DATA_W-1:0] data,
    output logic              src,
    output logic              valid
);

    logic can_load;
    logic load;
    logic winner;

    assign can_load = !valid | ready_out;
    // Ready must stay low while reset is held, even though it is combinational.
    assign load     = can_load & (|req) & !rst;

`ifdef RESP_XBAR_RR_EN
    logic last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT_2;
        end else if (load) begin
            last_grant <= winner;
        end
    end

    always_comb begin
        winner = first_req(req);
        if (req == 2'b11) begin
            winner = ~last_grant;
        end
    end
`else
    assign winner = first_req(req);
`endif

    assign grant = load ? ((winner == PORT_2) ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            src   <= PORT_1;
        end else if (load) begin
            valid <= 1'b1;
            data  <= (winner == PORT_2) ? data_s2 : data_s1;
            src   <= winner;
        end else if (ready_out) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/handshaking_resp_xbar_2x2.sv
// Return-path 2x2 crossbar: routes S1/S2 response beats to M1/M2 by destination tag.
// Arbitration mode is set by RESP_XBAR_RR_EN (round-robin) or its absence (S1 priority).
module handshaking_resp_xbar_2x2
    import hs_xbar_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_out_s1,
    input  logic              dest_s1,
    input  logic              valid_out_s1,
    output logic              ready_in_s1,
    input  logic [DATA_W-1:0] data_out_s2,
    input  logic              dest_s2,
    input  logic              valid_out_s2,
    output logic              ready_in_s2,
    output logic [DATA_W-1:0] data_in_m1,
    output logic              src_m1,
    output logic              valid_in_m1,
    input  logic              ready_out_m1,
    output logic [DATA_W-1:0] data_in_m2,
    output logic              src_m2,
    output logic              valid_in_m2,
    input  logic              ready_out_m2
);

    logic [1:0] req_m1;
    logic [1:0] req_m2;
    logic [1:0] grant_m1;
    logic [1:0] grant_m2;

    // Bit 0 is S1, bit 1 is S2 in every request/grant vector.
    assign req_m1 = {valid_out_s2 & (dest_s2 == PORT_1), valid_out_s1 & (dest_s1 == PORT_1)};
    assign req_m2 = {valid_out_s2 & (dest_s2 == PORT_2), valid_out_s1 & (dest_s1 == PORT_2)};

    hs_resp_arb_slice #(.DATA_W(DATA_W)) u_slice_m1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req_m1),
        .data_s1   (data_out_s1),
        .data_s2   (data_out_s2),
        .ready_out (ready_out_m1),
        .grant     (grant_m1),
        .data      (data_in_m1),
        .src       (src_m1),
        .valid     (valid_in_m1)
    );

    hs_resp_arb_slice #(.DATA_W(DATA_W)) u_slice_m2 (
        .clk       (clk),
        .rst       (rst),
        .req       (req_m2),
        .data_s1   (data_out_s1),
        .data_s2   (data_out_s2),
        .ready_out (ready_out_m2),
        .grant     (grant_m2),
        .data      (data_in_m2),
        .src       (src_m2),
        .valid     (valid_in_m2)
    );

    // A slave only requests the slice its dest selects, so OR-ing both grants is exact.
    assign ready_in_s1 = grant_m1[0] | grant_m2[0];
    assign ready_in_s2 = grant_m1[1] | grant_m2[1];

endmodule

// File: tb/tb_handshaking_resp_xbar_2x2.sv
// Self-checking bench for handshaking_resp_xbar_2x2: directed scenarios plus random traffic
// compared each cycle against a transaction-level reference model.
module tb_handshaking_resp_xbar_2x2;

    localparam int DATA_W = 8;
`ifdef RESP_XBAR_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              s_v   [2];
    logic [DATA_W-1:0] s_d   [2];
    logic              s_dst [2];
    logic              m_rdy [2];

    logic              ready_in_s1, ready_in_s2;
    logic [DATA_W-1:0] data_in_m1, data_in_m2;
    logic              src_m1, src_m2, valid_in_m1, valid_in_m2;

    // Reference model: per-master output slot and last winner.
    logic              e_v   [2];
    logic [DATA_W-1:0] e_d   [2];
    logic              e_src [2];
    logic              e_lg  [2];

    logic [1:0] obs_rdy;
    int total = 0;
    int bad = 0;
    int cnt_2f = 0;

    always #5 clk = ~clk;

    handshaking_resp_xbar_2x2 #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_out_s1  (s_d[0]),
        .dest_s1      (s_dst[0]),
        .valid_out_s1 (s_v[0]),
        .ready_in_s1  (ready_in_s1),
        .data_out_s2  (s_d[1]),
        .dest_s2      (s_dst[1]),
        .valid_out_s2 (s_v[1]),
        .ready_in_s2  (ready_in_s2),
        .data_in_m1   (data_in_m1),
        .src_m1       (src_m1),
        .valid_in_m1  (valid_in_m1),
        .ready_out_m1 (m_rdy[0]),
        .data_in_m2   (data_in_m2),
        .src_m2       (src_m2),
        .valid_in_m2  (valid_in_m2),
        .ready_out_m2 (m_rdy[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            e_v[m] = 1'b0; e_d[m] = '0; e_src[m] = 1'b0; e_lg[m] = 1'b1;
        end
    endtask

    // One clock cycle: check at negedge, advance model at posedge, retire accepted slave beats.
    task automatic step();
        logic [1:0] er;
        logic eg [2];
        logic ew [2];
        logic r0, r1;
        @(negedge clk);
        er = 2'b00;
        for (int m = 0; m < 2; m++) begin
            eg[m] = 1'b0;
            ew[m] = 1'b0;
            r0 = s_v[0] && (s_dst[0] == m[0]);
            r1 = s_v[1] && (s_dst[1] == m[0]);
            if (!rst && (!e_v[m] || m_rdy[m]) && (r0 || r1)) begin
                eg[m] = 1'b1;
                if (r0 && r1) ew[m] = RR ? !e_lg[m] : 1'b0;
                else          ew[m] = r1;
                er[ew[m]] = 1'b1;
            end
        end
        chk("rdy_s1", ready_in_s1, er[0]);
        chk("rdy_s2", ready_in_s2, er[1]);
        chk("v_m1", valid_in_m1, e_v[0]);
        chk("d_m1", data_in_m1, e_d[0]);
        chk("src_m1", src_m1, e_src[0]);
        chk("v_m2", valid_in_m2, e_v[1]);
        chk("d_m2", data_in_m2, e_d[1]);
        chk("src_m2", src_m2, e_src[1]);
        obs_rdy = {ready_in_s2, ready_in_s1};
        if (valid_in_m1 && m_rdy[0] && data_in_m1 == 8'h2f) cnt_2f++;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (eg[m]) begin
                    e_v[m] = 1'b1; e_d[m] = s_d[ew[m]]; e_src[m] = ew[m]; e_lg[m] = ew[m];
                end else if (m_rdy[m]) begin
                    e_v[m] = 1'b0;
                end
            end
        end
        #1;
        for (int s = 0; s < 2; s++) if (er[s]) s_v[s] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        m_rdy[0] = 1'b1; m_rdy[1] = 1'b1;
        while ((s_v[0] || s_v[1]) && n < 20) begin
            step();
            n++;
        end
        if (s_v[0] || s_v[1]) chk("drain_timeout", 1, 0);
        step();
    endtask

    task automatic offer(input int s, input logic [7:0] d, input logic dst);
        s_v[s] = 1'b1; s_d[s] = d; s_dst[s] = dst;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            s_v[s] = 1'b0; s_d[s] = '0; s_dst[s] = 1'b0; m_rdy[s] = 1'b1;
        end
        model_reset();
        step();
        step();
        rst = 1'b0;

        // Single route S1 -> M1
        offer(0, 8'h20, 1'b0);
        step();
        chk("single_rdy", obs_rdy, 2'b01);
        chk("single_v", valid_in_m1, 1);
        chk("single_d", data_in_m1, 8'h20);
        chk("single_src", src_m1, 0);
        chk("single_m2idle", valid_in_m2, 0);
        step();

        // Parallel routes S1 -> M2, S2 -> M1
        offer(0, 8'h30, 1'b1);
        offer(1, 8'h38, 1'b0);
        step();
        chk("par_rdy", obs_rdy, 2'b11);
        chk("par_d_m2", data_in_m2, 8'h30);
        chk("par_src_m2", src_m2, 0);
        chk("par_d_m1", data_in_m1, 8'h38);
        chk("par_src_m1", src_m1, 1);
        step();

        // Contention on M1, both slaves streaming
        for (int i = 0; i < 6; i++) begin
            for (int s = 0; s < 2; s++)
                if (!s_v[s]) offer(s, 8'(s * 8'h40 + i), 1'b0);
            step();
            chk("cont_src", src_m1, RR ? i % 2 : 0);
            chk("cont_rdy_s2", obs_rdy[1], RR ? i % 2 : 0);
        end
        drain();

        // Backpressure on M1 with 0x2f registered
        cnt_2f = 0;
        offer(0, 8'h2f, 1'b0);
        step();
        m_rdy[0] = 1'b0;
        offer(0, 8'h41, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold", data_in_m1, 8'h2f);
            chk("bp_rdy_s1", obs_rdy[0], 0);
        end
        m_rdy[0] = 1'b1;
        step();
        chk("bp_reload_rdy", obs_rdy[0], 1);
        chk("bp_next_d", data_in_m1, 8'h41);
        chk("bp_next_v", valid_in_m1, 1);
        step();
        chk("bp_once", cnt_2f, 1);

        // Reset while M2 holds a beat
        m_rdy[1] = 1'b0;
        offer(0, 8'h55, 1'b1);
        step();
        chk("rmt_v_before", valid_in_m2, 1);
        #2 rst = 1'b1;
        #1;
        chk("rmt_v_m2", valid_in_m2, 0);
        chk("rmt_d_m2", data_in_m2, 0);
        chk("rmt_v_m1", valid_in_m1, 0);
        model_reset();
        offer(0, 8'h66, 1'b0);
        step();
        chk("rst_force_rdy", obs_rdy, 2'b00);
        rst = 1'b0;
        m_rdy[1] = 1'b1;
        offer(1, 8'h77, 1'b0);
        step();
        chk("post_rst_s1_wins", obs_rdy, 2'b01);
        chk("post_rst_m2_idle", valid_in_m2, 0);
        drain();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            for (int s = 0; s < 2; s++)
                if (!s_v[s] && $urandom_range(0, 9) < 6)
                    offer(s, 8'($urandom), 1'($urandom));
            m_rdy[0] = ($urandom_range(0, 9) < 7);
            m_rdy[1] = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
